// File: rtl/fft_input_loader.sv
// Serial-to-parallel frame loader for the 64-point FFT engine: samples land in
// bit-reversed slots, the frame is announced with start and held until fft_done.
//
// state | meaning
// FILL  | accepting samples into the frame buffer
// START | frame complete, one-cycle start pulse to the engine
// HOLD  | engine owns the frame, wait for fft_done
module fft_input_loader #(
  parameter int D_WIDTH     = 64,
  parameter int LOG_2_WIDTH = 6,
  parameter int S_WIDTH     = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic [S_WIDTH-1:0]     in_re,
  input  logic [S_WIDTH-1:0]     in_im,
  output logic                   in_ready,
  input  logic                   flush,
  input  logic                   fft_done,
  output logic [S_WIDTH-1:0]     output_Re [D_WIDTH],
  output logic [S_WIDTH-1:0]     output_Im [D_WIDTH],
  output logic                   start,
  output logic                   busy,
  output logic [LOG_2_WIDTH:0]   fill_count
);

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    START = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t                 state_q;
  logic [LOG_2_WIDTH:0]   fill_count_q;
  logic                   start_q;
  logic                   busy_q;
  logic                   ready_q;
  logic [S_WIDTH-1:0]     re_q [D_WIDTH];
  logic [S_WIDTH-1:0]     im_q [D_WIDTH];

  logic [LOG_2_WIDTH-1:0] idx;
  logic [LOG_2_WIDTH-1:0] slot;

  // In FILL the count never exceeds D_WIDTH-1, so its low bits are the write index.
  assign idx = fill_count_q[LOG_2_WIDTH-1:0];

  always_comb begin
    slot = '0;
    for (int b = 0; b < LOG_2_WIDTH; b++) begin
      slot[b] = idx[LOG_2_WIDTH-1-b];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= FILL;
      fill_count_q <= '0;
      start_q      <= 1'b0;
      busy_q       <= 1'b0;
      ready_q      <= 1'b1;
      for (int i = 0; i < D_WIDTH; i++) begin
        re_q[i] <= '0;
        im_q[i] <= '0;
      end
    end else begin
      case (state_q)
        FILL: begin
          // flush wins over a simultaneous handshake; that sample is dropped
          if (flush) begin
            fill_count_q <= '0;
          end else if (in_valid) begin
            re_q[slot] <= in_re;
            im_q[slot] <= in_im;
            if (idx == LOG_2_WIDTH'(D_WIDTH - 1)) begin
              state_q      <= START;
              fill_count_q <= (LOG_2_WIDTH+1)'(D_WIDTH);
              start_q      <= 1'b1;
              busy_q       <= 1'b1;
              ready_q      <= 1'b0;
            end else begin
              fill_count_q <= fill_count_q + (LOG_2_WIDTH+1)'(1);
            end
          end
        end
        START: begin
          state_q <= HOLD;
          start_q <= 1'b0;
        end
        HOLD: begin
          if (fft_done) begin
            state_q      <= FILL;
            fill_count_q <= '0;
            busy_q       <= 1'b0;
            ready_q      <= 1'b1;
          end
        end
        default: begin
          state_q      <= FILL;
          fill_count_q <= '0;
          start_q      <= 1'b0;
          busy_q       <= 1'b0;
          ready_q      <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready   = ready_q & ~rst;
  assign start      = start_q;
  assign busy       = busy_q;
  assign fill_count = fill_count_q;
  assign output_Re  = re_q;
  assign output_Im  = im_q;

endmodule

// File: tb/tb_fft_input_loader.sv
// Randomized bench for fft_input_loader: a frame-level reference model pushes
// expected frames into a scoreboard, and a monitor checks them on each start pulse.
module tb_fft_input_loader;

  localparam int N = 64;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic [15:0]       in_re;
  logic [15:0]       in_im;
  logic              in_ready;
  logic              flush;
  logic              fft_done;
  logic [15:0]       output_Re [N];
  logic [15:0]       output_Im [N];
  logic              start;
  logic              busy;
  logic [6:0]        fill_count;

  fft_input_loader #(.D_WIDTH(64), .LOG_2_WIDTH(6), .S_WIDTH(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_re      (in_re),
    .in_im      (in_im),
    .in_ready   (in_ready),
    .flush      (flush),
    .fft_done   (fft_done),
    .output_Re  (output_Re),
    .output_Im  (output_Im),
    .start      (start),
    .busy       (busy),
    .fill_count (fill_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: frame contents as plain arrays, phase 0=filling 1=start 2=held
  logic [N-1:0][15:0] m_re, m_im;
  int                 m_cnt;
  int                 m_phase;
  logic [N-1:0][15:0] exp_re_q [$];
  logic [N-1:0][15:0] exp_im_q [$];

  function automatic int brev(input int k);
    int r = 0;
    for (int b = 0; b < 6; b++) if ((k >> b) % 2 == 1) r += 32 >> b;
    return r;
  endfunction

  task automatic model_reset();
    m_re = '0;
    m_im = '0;
    m_cnt = 0;
    m_phase = 0;
    exp_re_q.delete();
    exp_im_q.delete();
  endtask

  // Advance one clock: update model from current inputs, then compare Moore outputs.
  task automatic step();
    if (rst) begin
      model_reset();
    end else begin
      case (m_phase)
        0: begin
          if (flush) m_cnt = 0;
          else if (in_valid) begin
            m_re[brev(m_cnt)] = in_re;
            m_im[brev(m_cnt)] = in_im;
            m_cnt++;
            if (m_cnt == N) begin
              exp_re_q.push_back(m_re);
              exp_im_q.push_back(m_im);
              m_phase = 1;
            end
          end
        end
        1: m_phase = 2;
        default: if (fft_done) begin
          m_phase = 0;
          m_cnt = 0;
        end
      endcase
    end
    @(posedge clk);
    #1;
    if (rst) begin
      chk("rst_in_ready", in_ready, 0);
      chk("rst_start", start, 0);
      chk("rst_busy", busy, 0);
      chk("rst_fill_count", fill_count, 0);
    end else begin
      chk("in_ready", in_ready, m_phase == 0);
      chk("start", start, m_phase == 1);
      chk("busy", busy, m_phase != 0);
      chk("fill_count", fill_count, (m_phase == 0) ? m_cnt : N);
    end
  endtask

  function automatic int nonzero_entries();
    int c = 0;
    for (int i = 0; i < N; i++) if (output_Re[i] !== 16'h0 || output_Im[i] !== 16'h0) c++;
    return c;
  endfunction

  function automatic int diff_frame(input logic [N-1:0][15:0] er, input logic [N-1:0][15:0] ei);
    int c = 0;
    for (int i = 0; i < N; i++) if (output_Re[i] !== er[i] || output_Im[i] !== ei[i]) c++;
    return c;
  endfunction

  // Monitor: pops the expected frame on each start, then watches it stay stable.
  logic [N-1:0][15:0] held_re, held_im;
  logic               prev_start = 1'b0;

  always @(negedge clk) begin
    if (!rst && start) begin
      chk("start_single_cycle", prev_start, 0);
      if (exp_re_q.size() == 0) begin
        chk("start_unexpected", 1, 0);
      end else begin
        held_re = exp_re_q.pop_front();
        held_im = exp_im_q.pop_front();
        chk("frame_mismatch_slots", diff_frame(held_re, held_im), 0);
      end
    end else if (!rst && busy) begin
      chk("hold_stable_slots", diff_frame(held_re, held_im), 0);
    end
    prev_start = start;
  end

  task automatic release_frame(input int hold_cycles);
    in_valid = 1'b0;
    for (int i = 0; i < hold_cycles; i++) step();
    fft_done = 1'b1;
    step();
    fft_done = 1'b0;
  endtask

  task automatic load_random_frame();
    for (int k = 0; k < N; k++) begin
      in_valid = 1'b1;
      in_re = 16'($urandom);
      in_im = 16'($urandom);
      step();
    end
    in_valid = 1'b0;
  endtask

  initial begin
    int guard;
    rst = 1'b1;
    in_valid = 1'b1;
    in_re = 16'($urandom);
    in_im = 16'($urandom);
    flush = 1'b0;
    fft_done = 1'b0;
    model_reset();

    // Reset with in_valid high
    step();
    step();
    chk("reset_buf_nonzero", nonzero_entries(), 0);
    rst = 1'b0;
    #1;
    chk("in_ready_after_release", in_ready, 1);
    in_valid = 1'b0;
    step();

    // Bit-reverse load, back to back; fft_done pulsed in FILL is ignored
    for (int k = 0; k < N; k++) begin
      in_valid = 1'b1;
      in_re = 16'(k);
      in_im = 16'(16'hFFFF - k);
      fft_done = (k == 20);
      step();
    end
    fft_done = 1'b0;
    chk("re_slot32", output_Re[32], 1);
    chk("re_slot1", output_Re[1], 32);
    chk("re_slot48", output_Re[48], 3);
    chk("re_slot63", output_Re[63], 63);
    chk("im_slot32", output_Im[32], 16'hFFFE);

    // In START: fft_done and flush ignored, in_valid ignored
    fft_done = 1'b1;
    flush = 1'b1;
    step();
    fft_done = 1'b0;

    // HOLD with in_valid high and occasional flush
    for (int i = 0; i < 20; i++) begin
      in_valid = 1'b1;
      in_re = 16'($urandom);
      in_im = 16'($urandom);
      flush = ($urandom_range(0, 3) == 0);
      step();
    end
    flush = 1'b0;
    release_frame(0);

    // Random in_valid gaps, fft_done noise in FILL
    guard = 0;
    while (m_phase == 0 && guard < 2000) begin
      in_valid = ($urandom_range(0, 2) != 0);
      in_re = 16'($urandom);
      in_im = 16'($urandom);
      fft_done = ($urandom_range(0, 7) == 0);
      step();
      guard++;
    end
    fft_done = 1'b0;
    chk("gap_frame_completed", (m_phase != 0), 1);
    release_frame($urandom_range(1, 10));

    // Flush after a partial frame
    for (int k = 0; k < 10; k++) begin
      in_valid = 1'b1;
      in_re = 16'(100 + k);
      in_im = 16'($urandom);
      step();
    end
    flush = 1'b1;
    in_valid = 1'b1;
    in_re = 16'h7777;
    step();
    chk("fill_count_after_flush", fill_count, 0);
    flush = 1'b0;
    for (int k = 0; k < N; k++) begin
      in_valid = 1'b1;
      in_re = 16'(k);
      in_im = 16'($urandom);
      step();
    end
    in_valid = 1'b0;
    guard = 0;
    for (int k = 0; k < N; k++) if (output_Re[brev(k)] !== 16'(k)) guard++;
    chk("flush_reload_bad_slots", guard, 0);
    release_frame(3);

    // Reset mid-HOLD, then a fresh frame
    load_random_frame();
    step();
    step();
    chk("busy_before_rst", busy, 1);
    rst = 1'b1;
    step();
    chk("midhold_rst_buf_nonzero", nonzero_entries(), 0);
    rst = 1'b0;
    step();
    load_random_frame();
    release_frame(2);
    step();
    chk("scoreboard_drained", exp_re_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
